// File: rtl/sha_msg_sched.sv
// SHA-256 multi-block message sequencer: feeds padded blocks to one compression core,
// chains H between blocks and holds the final digest. Optional macro: SHA_SCHED_TIMEOUT_EN.
module sha_msg_sched #(
  parameter int CNT_W       = 16,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  blk_valid,
  output logic                  blk_ready,
  input  logic [0:15][31:0]     blk_data,
  input  logic                  blk_first,
  input  logic                  blk_last,
  output logic                  core_start,
  output logic [0:7][31:0]      core_H_in,
  output logic [0:15][31:0]     core_W,
  input  logic                  core_done,
  input  logic [0:7][31:0]      core_H_out,
  output logic                  dig_valid,
  input  logic                  dig_ready,
  output logic [0:7][31:0]      digest,
  output logic [CNT_W-1:0]      blk_cnt,
  output logic                  busy,
  output logic                  err
);

  localparam logic [0:7][31:0] H0_IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_DONE} state_t;

  state_t            state, state_nxt;
  logic [0:7][31:0]  chain;
  logic [0:15][31:0] w_blk;
  logic              msg_open;
  logic              last_blk;
  logic              accept;
  logic              take_blk;
  logic              core_fin;
  logic              timeout;

  // Accept only happens in IDLE because blk_ready is registered from the IDLE decision.
  assign accept   = blk_valid & blk_ready;
  assign take_blk = accept & (blk_first | msg_open);
  assign core_fin = (state == S_WAIT) & core_done;

`ifdef SHA_SCHED_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] tmo_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tmo_cnt <= '0;
    end else if (state == S_START) begin
      tmo_cnt <= '0;
    end else if (state == S_WAIT) begin
      tmo_cnt <= tmo_cnt + TW'(1);
    end
  end

  // A core_done arriving on the final counted cycle still completes normally.
  assign timeout = (state == S_WAIT) & ~core_done & (tmo_cnt == TW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err <= 1'b0;
    end else if (timeout) begin
      err <= 1'b1;
    end else if (accept & blk_first) begin
      err <= 1'b0;
    end
  end
`else
  assign timeout = 1'b0;
  // Never true; the wait limit only matters in the timeout build.
  assign err     = (TIMEOUT_CYC < 0);
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (take_blk) state_nxt = S_START;
      S_START: state_nxt = S_WAIT;
      S_WAIT: begin
        if (core_done)    state_nxt = last_blk ? S_DONE : S_IDLE;
        else if (timeout) state_nxt = S_IDLE;
      end
      S_DONE:  if (dig_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Control outputs are registered from the next state so they are glitch-free and zero in reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      blk_ready  <= 1'b0;
      core_start <= 1'b0;
      dig_valid  <= 1'b0;
      busy       <= 1'b0;
      msg_open   <= 1'b0;
      last_blk   <= 1'b0;
      blk_cnt    <= '0;
    end else begin
      state      <= state_nxt;
      blk_ready  <= (state_nxt == S_IDLE);
      core_start <= (state_nxt == S_START);
      dig_valid  <= (state_nxt == S_DONE);
      busy       <= (state_nxt != S_IDLE);
      if (take_blk) begin
        last_blk <= blk_last;
        if (blk_first) begin
          msg_open <= 1'b1;
          blk_cnt  <= '0;
        end
      end
      if (core_fin) begin
        if (blk_cnt != '1) blk_cnt <= blk_cnt + CNT_W'(1);
        if (last_blk)      msg_open <= 1'b0;
      end
      if (timeout) msg_open <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      chain <= '0;
      w_blk <= '0;
    end else begin
      if (take_blk) begin
        w_blk <= blk_data;
        if (blk_first) chain <= H0_IV;
      end
      if (core_fin) chain <= core_H_out;
    end
  end

  assign core_H_in = chain;
  assign core_W    = w_blk;
  assign digest    = chain;

endmodule

// File: tb/tb_sha_msg_sched.sv
// Self-checking bench for sha_msg_sched with a behavioural SHA-256 core and message-level model.
module tb_sha_msg_sched;

  localparam int CNT_W = 2;
  localparam int TMO   = 100;

  localparam logic [31:0] K [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };
  localparam logic [255:0] IV = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                 32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
  localparam logic [511:0] ABC = {32'h61626380, 448'h0, 32'h18};
  localparam logic [255:0] ABC_DIG = {32'hba7816bf, 32'h8f01cfea, 32'h414140de, 32'h5dae2223,
                                      32'hb00361a3, 32'h96177a9c, 32'hb410ff61, 32'hf20015ad};

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 blk_valid, blk_ready, blk_first, blk_last;
  logic [0:15][31:0]    blk_data;
  logic                 core_start, core_done;
  logic [0:7][31:0]     core_H_in, core_H_out, digest;
  logic [0:15][31:0]    core_W;
  logic                 dig_valid, dig_ready;
  logic [CNT_W-1:0]     blk_cnt;
  logic                 busy, err;

  int errors = 0;
  int checks = 0;
  int n_start = 0;
  logic core_hold = 1'b0;
  logic inj_done  = 1'b0;

  sha_msg_sched #(.CNT_W(CNT_W), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .reset(reset),
    .blk_valid(blk_valid), .blk_ready(blk_ready), .blk_data(blk_data),
    .blk_first(blk_first), .blk_last(blk_last),
    .core_start(core_start), .core_H_in(core_H_in), .core_W(core_W),
    .core_done(core_done), .core_H_out(core_H_out),
    .dig_valid(dig_valid), .dig_ready(dig_ready), .digest(digest),
    .blk_cnt(blk_cnt), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] compress(input logic [255:0] h, input logic [511:0] blk);
    logic [31:0] w [64];
    logic [31:0] a, b, c, d, e, f, g, hh, t1, t2, s0, s1;
    for (int i = 0; i < 16; i++) w[i] = blk[511 - 32*i -: 32];
    for (int i = 16; i < 64; i++) begin
      s0 = rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3);
      s1 = rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10);
      w[i] = w[i-16] + s0 + w[i-7] + s1;
    end
    {a, b, c, d, e, f, g, hh} = h;
    for (int i = 0; i < 64; i++) begin
      t1 = hh + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + K[i] + w[i];
      t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      hh = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
    end
    return {h[255:224] + a, h[223:192] + b, h[191:160] + c, h[159:128] + d,
            h[127:96] + e, h[95:64] + f, h[63:32] + g, h[31:0] + hh};
  endfunction

  // Golden core: answers each core_start after a random 1..6 cycle latency unless held.
  initial begin
    logic [255:0] res;
    logic         pend;
    int           cd;
    pend = 1'b0; cd = 0; res = '0;
    core_done = 1'b0; core_H_out = '0;
    forever begin
      @(posedge clk); #1;
      core_done = 1'b0;
      if (inj_done) begin
        core_H_out = {8{$urandom}};
        core_done  = 1'b1;
        inj_done   = 1'b0;
      end
      if (pend) begin
        if (core_hold) pend = 1'b0;
        else if (cd == 0) begin
          core_H_out = res; core_done = 1'b1; pend = 1'b0;
        end else cd--;
      end
      if (core_start) begin
        n_start++;
        res  = compress(core_H_in, core_W);
        pend = 1'b1;
        cd   = $urandom_range(0, 5);
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_ctl"}, {blk_ready, core_start, dig_valid, busy, err, blk_cnt}, '0);
    chk({nm, "_digest"}, digest, '0);
    chk({nm, "_core_h"}, core_H_in, '0);
    chk({nm, "_core_w"}, core_W[0:7], '0);
    chk({nm, "_core_w_hi"}, core_W[8:15], '0);
  endtask

  task automatic send(input logic f, input logic l, input logic [511:0] d);
    int t = 0;
    blk_valid = 1'b1; blk_first = f; blk_last = l; blk_data = d;
    while (!blk_ready && t < 500) begin @(posedge clk); #1; t++; end
    chk("blk_ready_wait", blk_ready, 1);
    @(posedge clk); #1;
    blk_valid = 1'b0; blk_first = 1'b0; blk_last = 1'b0;
  endtask

  task automatic wait_dig(input logic [255:0] exp, input int cnt, input int hold);
    int t = 0;
    while (!dig_valid && t < 300) begin @(posedge clk); #1; t++; end
    chk("dig_valid", dig_valid, 1);
    chk("digest", digest, exp);
    chk("blk_cnt", blk_cnt, cnt);
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      chk("hold_valid", dig_valid, 1);
      chk("hold_digest", digest, exp);
      chk("hold_ready", blk_ready, 0);
    end
    dig_ready = 1'b1;
    @(posedge clk); #1;
    dig_ready = 1'b0;
    chk("dig_drop", dig_valid, 0);
    chk("idle_busy", busy, 0);
    chk("idle_ready", blk_ready, 1);
  endtask

  typedef struct {
    logic [511:0] b0;
    logic [511:0] b1;
    int           nb;
    logic [255:0] exp;
  } vec_t;

  initial begin
    vec_t         vt [2];
    logic [511:0] d;
    logic [255:0] h;
    int           s, nb, cexp;
    logic         rst_w;

    vt[0] = '{b0: ABC, b1: '0, nb: 1, exp: ABC_DIG};
    vt[1] = '{b0: {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                   32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                   32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                   32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000},
              b1: {480'h0, 32'h1c0}, nb: 2,
              exp: {32'h248d6a61, 32'hd20638b8, 32'he5c02693, 32'h0c3e6039,
                    32'ha33ce459, 32'h64ff2167, 32'hf6ecedd4, 32'h19db06c1}};

    reset = 1'b0; blk_valid = 1'b0; blk_first = 1'b0; blk_last = 1'b0;
    blk_data = '0; dig_ready = 1'b0;
    #1;
    chk_zero("reset");
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;

    // Orphan block straight after reset
    s = n_start;
    send(1'b0, 1'b1, ABC);
    repeat (10) @(posedge clk);
    #1;
    chk("orphan_starts", n_start, s);
    chk("orphan_cnt", blk_cnt, 0);
    chk("orphan_busy", busy, 0);

    // Known-answer vectors
    for (int i = 0; i < 2; i++) begin
      s = n_start;
      send(1'b1, vt[i].nb == 1, vt[i].b0);
      if (vt[i].nb == 2) send(1'b0, 1'b1, vt[i].b1);
      wait_dig(vt[i].exp, vt[i].nb, 0);
      chk("kat_starts", n_start - s, vt[i].nb);
    end

    // Digest held while the consumer stalls
    send(1'b1, 1'b1, ABC);
    wait_dig(ABC_DIG, 1, 10);

    // Reset asserted three cycles into WAIT
    core_hold = 1'b1;
    send(1'b1, 1'b1, ABC);
    @(posedge clk);
    repeat (3) @(posedge clk);
    #3 reset = 1'b0;
    #1;
    chk_zero("midreset");
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    core_hold = 1'b0;
    @(posedge clk); #1;
    inj_done = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("late_done_busy", busy, 0);
    chk("late_done_valid", dig_valid, 0);
    chk("late_done_cnt", blk_cnt, 0);
    send(1'b1, 1'b1, ABC);
    wait_dig(ABC_DIG, 1, 0);

`ifdef SHA_SCHED_TIMEOUT_EN
    core_hold = 1'b1;
    s = n_start;
    send(1'b1, 1'b1, ABC);
    @(posedge clk); #1;
    repeat (TMO - 1) @(posedge clk);
    #1;
    chk("tmo_pre_busy", busy, 1);
    chk("tmo_pre_err", err, 0);
    @(posedge clk); #1;
    chk("tmo_busy", busy, 0);
    chk("tmo_err", err, 1);
    core_hold = 1'b0;
    send(1'b0, 1'b1, ABC);
    repeat (5) @(posedge clk);
    #1;
    chk("tmo_orphan_starts", n_start - s, 1);
    chk("tmo_err_sticky", err, 1);
    send(1'b1, 1'b1, ABC);
    chk("tmo_err_clear", err, 0);
    wait_dig(ABC_DIG, 1, 0);
`endif

    // Random messages against the message-level model, with restarts and orphans
    for (int m = 0; m < 25; m++) begin
      s = n_start;
      if (m % 5 == 2) begin
        for (int k = 0; k < 16; k++) d[k*32 +: 32] = $urandom;
        send(1'b1, 1'b0, d);
        s = s + 1;
      end
      nb = $urandom_range(1, 5);
      h  = IV;
      for (int b = 0; b < nb; b++) begin
        for (int k = 0; k < 16; k++) d[k*32 +: 32] = $urandom;
        send(b == 0, b == nb - 1, d);
        h = compress(h, d);
      end
      cexp = (nb > 3) ? 3 : nb;
      wait_dig(h, cexp, $urandom_range(0, 3));
      chk("rand_starts", n_start - s, nb);
      if (m % 4 == 3) begin
        s = n_start;
        for (int k = 0; k < 16; k++) d[k*32 +: 32] = $urandom;
        rst_w = $urandom_range(0, 1);
        send(1'b0, rst_w, d);
        repeat (8) @(posedge clk);
        #1;
        chk("rand_orphan_starts", n_start, s);
        chk("rand_orphan_busy", busy, 0);
        chk("rand_orphan_cnt", blk_cnt, cexp);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
